// File: rtl/lc3b_types.sv
// Shared types for the LC-3b pipeline control logic.
// Contents:
//   lc3b_pctrl_state - MEM-stage access sequencer state
//     ACC1 : first (or only) data access of the instruction in exmem
//     ACC2 : second access of an LDI/STI, after the pointer was fetched
//     HOLD : data access finished, waiting for the IF stage to catch up
package lc3b_types;

  typedef enum logic [1:0] {
    ACC1 = 2'd0,
    ACC2 = 2'd1,
    HOLD = 2'd2
  } lc3b_pctrl_state;

endpackage

// File: rtl/pipe_perf_cnt.sv
// Saturating event counter used for pipeline performance statistics.
// Ports:
//   clk    - clock
//   rst_n  - asynchronous active-low reset, clears the count
//   i_inc  - count enable for this cycle
//   o_cnt  - current count, sticks at all-ones
module pipe_perf_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/lc3b_pipe_ctrl.sv
// Stall/flush sequencer for the 5-stage LC-3b pipeline.
// Drives advance/flush of the ifid, idex, exmem, memwb registers and the PC
// enable/mux, sequences MEM-stage data accesses (two accesses for LDI/STI)
// and arbitrates memory stalls, load-use bubbles and taken redirects.
// Optional build macro: LC3B_PIPE_PERF_EN adds stall_cycles, bubble_cnt and
// redirect_cnt saturating counters (CNT_W bits each).
// Ports:
//   clk, rst_n                 - clock, asynchronous active-low reset
//   imem_read, imem_resp       - IF fetch request / response pulse
//   mem_dreq, mem_dwrite       - exmem needs a data access / it is a store
//   mem_indirect               - exmem holds LDI/STI
//   dmem_resp                  - D-memory response pulse
//   id_load_use                - load-use hazard between idex and ID
//   mem_br_taken               - exmem resolves a taken redirect
//   dmem_read, dmem_write      - D-memory strobes
//   ind_latch                  - capture indirect pointer into MAR
//   advance_*, flush_*         - pipeline register controls
//   pc_load, pc_redirect       - PC enable and target select
module lc3b_pipe_ctrl
  import lc3b_types::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             imem_read,
  input  logic             imem_resp,
  input  logic             mem_dreq,
  input  logic             mem_dwrite,
  input  logic             mem_indirect,
  input  logic             dmem_resp,
  input  logic             id_load_use,
  input  logic             mem_br_taken,
  output logic             dmem_read,
  output logic             dmem_write,
  output logic             ind_latch,
  output logic             advance_ifid,
  output logic             advance_idex,
  output logic             advance_exmem,
  output logic             advance_memwb,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             flush_exmem,
  output logic             pc_load,
  output logic             pc_redirect
`ifdef LC3B_PIPE_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] redirect_cnt
`endif
);

  lc3b_pctrl_state r_st;
  lc3b_pctrl_state w_st_next;
  logic w_rd, w_wr, w_il, w_mem_done;
  logic w_istall, w_dstall, w_stall;

  // Access sequencing: strobes and completion depend only on state and inputs.
  always_comb begin
    w_rd       = 1'b0;
    w_wr       = 1'b0;
    w_il       = 1'b0;
    w_mem_done = 1'b0;
    case (r_st)
      ACC1: begin
        // An indirect access always reads the pointer first, even for STI.
        w_rd = mem_dreq & (mem_indirect | ~mem_dwrite);
        w_wr = mem_dreq & ~mem_indirect & mem_dwrite;
        if (dmem_resp) begin
          if (mem_indirect) w_il = 1'b1;
          else              w_mem_done = 1'b1;
        end
      end
      ACC2: begin
        w_rd       = ~mem_dwrite;
        w_wr       = mem_dwrite;
        w_mem_done = dmem_resp;
      end
      HOLD: begin
        // Data already captured; do not re-issue while IF is still stalled.
        w_mem_done = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_istall = imem_read & ~imem_resp;
  assign w_dstall = mem_dreq & ~w_mem_done;
  assign w_stall  = w_istall | w_dstall;

  always_comb begin
    w_st_next = r_st;
    if (!w_stall)                   w_st_next = ACC1;
    else if (w_mem_done & w_istall) w_st_next = HOLD;
    else if (w_il)                  w_st_next = ACC2;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_st <= ACC1;
    else        r_st <= w_st_next;
  end

  // Pipeline controls. Reset forces every register into its cleared state.
  always_comb begin
    dmem_read     = 1'b0;
    dmem_write    = 1'b0;
    ind_latch     = 1'b0;
    advance_ifid  = 1'b0;
    advance_idex  = 1'b0;
    advance_exmem = 1'b0;
    advance_memwb = 1'b0;
    flush_ifid    = 1'b0;
    flush_idex    = 1'b0;
    flush_exmem   = 1'b0;
    pc_load       = 1'b0;
    pc_redirect   = 1'b0;
    if (!rst_n) begin
      flush_ifid  = 1'b1;
      flush_idex  = 1'b1;
      flush_exmem = 1'b1;
    end else begin
      dmem_read  = w_rd;
      dmem_write = w_wr;
      ind_latch  = w_il;
      if (w_stall) begin
        // whole pipe frozen, defaults already hold everything
      end else if (mem_br_taken) begin
        // Redirect wins over load-use: the younger instructions are discarded.
        advance_memwb = 1'b1;
        flush_ifid    = 1'b1;
        flush_idex    = 1'b1;
        flush_exmem   = 1'b1;
        pc_load       = 1'b1;
        pc_redirect   = 1'b1;
      end else if (id_load_use) begin
        // Hold IF/ID and PC, inject a bubble into idex.
        flush_idex    = 1'b1;
        advance_exmem = 1'b1;
        advance_memwb = 1'b1;
      end else begin
        advance_ifid  = 1'b1;
        advance_idex  = 1'b1;
        advance_exmem = 1'b1;
        advance_memwb = 1'b1;
        pc_load       = 1'b1;
      end
    end
  end

`ifdef LC3B_PIPE_PERF_EN
  logic w_bubble_ev, w_redirect_ev;
  assign w_bubble_ev   = ~w_stall & id_load_use & ~mem_br_taken;
  assign w_redirect_ev = ~w_stall & mem_br_taken;

  pipe_perf_cnt #(.W(CNT_W)) u_stall_cnt (
    .clk(clk), .rst_n(rst_n), .i_inc(w_stall), .o_cnt(stall_cycles)
  );
  pipe_perf_cnt #(.W(CNT_W)) u_bubble_cnt (
    .clk(clk), .rst_n(rst_n), .i_inc(w_bubble_ev), .o_cnt(bubble_cnt)
  );
  pipe_perf_cnt #(.W(CNT_W)) u_redirect_cnt (
    .clk(clk), .rst_n(rst_n), .i_inc(w_redirect_ev), .o_cnt(redirect_cnt)
  );
`endif

endmodule

// File: tb/tb_lc3b_pipe_ctrl.sv
// Self-checking bench for lc3b_pipe_ctrl. Expected outputs come from a model
// that tracks how many data accesses of the current instruction completed.
// Output vector bit order: {dmem_read, dmem_write, ind_latch,
//   advance_ifid, advance_idex, advance_exmem, advance_memwb,
//   flush_ifid, flush_idex, flush_exmem, pc_load, pc_redirect}
module tb_lc3b_pipe_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic imem_read, imem_resp, mem_dreq, mem_dwrite, mem_indirect;
  logic dmem_resp, id_load_use, mem_br_taken;
  logic dmem_read, dmem_write, ind_latch;
  logic advance_ifid, advance_idex, advance_exmem, advance_memwb;
  logic flush_ifid, flush_idex, flush_exmem, pc_load, pc_redirect;
`ifdef LC3B_PIPE_PERF_EN
  logic [15:0] stall_cycles, bubble_cnt, redirect_cnt;
  logic [15:0] m_stall, m_bubble, m_redir;
`endif
  logic [11:0] outv;

  int total, bad;
  int m_cnt;   // completed data accesses of the instruction in exmem

  always #5 clk = ~clk;

  lc3b_pipe_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_read(imem_read), .imem_resp(imem_resp),
    .mem_dreq(mem_dreq), .mem_dwrite(mem_dwrite), .mem_indirect(mem_indirect),
    .dmem_resp(dmem_resp), .id_load_use(id_load_use), .mem_br_taken(mem_br_taken),
    .dmem_read(dmem_read), .dmem_write(dmem_write), .ind_latch(ind_latch),
    .advance_ifid(advance_ifid), .advance_idex(advance_idex),
    .advance_exmem(advance_exmem), .advance_memwb(advance_memwb),
    .flush_ifid(flush_ifid), .flush_idex(flush_idex), .flush_exmem(flush_exmem),
    .pc_load(pc_load), .pc_redirect(pc_redirect)
`ifdef LC3B_PIPE_PERF_EN
    , .stall_cycles(stall_cycles), .bubble_cnt(bubble_cnt), .redirect_cnt(redirect_cnt)
`endif
  );

  assign outv = {dmem_read, dmem_write, ind_latch,
                 advance_ifid, advance_idex, advance_exmem, advance_memwb,
                 flush_ifid, flush_idex, flush_exmem, pc_load, pc_redirect};

  // Reference model: an instruction needs 1 access (2 if indirect); the first
  // access of an indirect op is a pointer read, the final one follows dwrite.
  function automatic void model_eval(output logic [11:0] e, output int nxt,
                                     output logic [2:0] ev);
    int need, cnt2;
    logic active, rsp, done, stall;
    e = '0; ev = '0; nxt = 0;
    if (!rst_n) begin
      e = 12'h01C;
      return;
    end
    need   = mem_indirect ? 2 : 1;
    active = mem_dreq && (m_cnt < need);
    e[11]  = active && ((m_cnt == 0) ? (mem_indirect || !mem_dwrite) : !mem_dwrite);
    e[10]  = active && ((m_cnt == 0) ? (!mem_indirect && mem_dwrite) : mem_dwrite);
    rsp    = active && dmem_resp;
    e[9]   = rsp && (m_cnt == 0) && mem_indirect;
    cnt2   = m_cnt + (rsp ? 1 : 0);
    done   = (cnt2 >= need);
    stall  = (imem_read && !imem_resp) || (mem_dreq && !done);
    nxt    = stall ? cnt2 : 0;
    if (stall) begin
      ev[0] = 1'b1;
    end else if (mem_br_taken) begin
      e[5] = 1'b1; e[4] = 1'b1; e[3] = 1'b1; e[2] = 1'b1; e[1] = 1'b1; e[0] = 1'b1;
      ev[2] = 1'b1;
    end else if (id_load_use) begin
      e[6] = 1'b1; e[5] = 1'b1; e[3] = 1'b1;
      ev[1] = 1'b1;
    end else begin
      e[8:5] = 4'hF; e[1] = 1'b1;
    end
  endfunction

  // One clock: sample at the falling edge, then advance the model.
  task automatic tick(output logic [11:0] o, output logic [11:0] e);
    int nxt;
    logic [2:0] ev;
    @(negedge clk);
    model_eval(e, nxt, ev);
    o = outv;
    @(posedge clk);
    m_cnt = nxt;
`ifdef LC3B_PIPE_PERF_EN
    if (ev[0] && m_stall  != 16'hFFFF) m_stall  = m_stall + 1'b1;
    if (ev[1] && m_bubble != 16'hFFFF) m_bubble = m_bubble + 1'b1;
    if (ev[2] && m_redir  != 16'hFFFF) m_redir  = m_redir + 1'b1;
`endif
    #1;
  endtask

  task automatic set_idle();
    imem_read = 1'b1; imem_resp = 1'b1; mem_dreq = 1'b0; mem_dwrite = 1'b0;
    mem_indirect = 1'b0; dmem_resp = 1'b0; id_load_use = 1'b0; mem_br_taken = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    imem_read = 1'b1; imem_resp = 1'b1; mem_dreq = 1'b1; mem_dwrite = 1'b0;
    mem_indirect = 1'b1; dmem_resp = 1'b1; id_load_use = 1'b1; mem_br_taken = 1'b1;
    #1;
    total++;
    if (outv !== 12'h01C) begin
      bad++; $display("FAIL reset_outputs got=%b want=%b", outv, 12'h01C);
    end
    @(posedge clk); #1;
`ifdef LC3B_PIPE_PERF_EN
    total++;
    if ({stall_cycles, bubble_cnt, redirect_cnt} !== 48'd0) begin
      bad++; $display("FAIL reset_counters got=%h want=0", {stall_cycles, bubble_cnt, redirect_cnt});
    end
    m_stall = '0; m_bubble = '0; m_redir = '0;
`endif
    set_idle();
    m_cnt = 0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    $display("reset: outputs checked while asserted");
  endtask

  task automatic test_add_stream();
    logic [11:0] o, e;
    set_idle();
    for (int i = 0; i < 5; i++) begin
      tick(o, e);
      total++;
      if (o !== 12'h1E2) begin
        bad++; $display("FAIL add_stream cyc=%0d got=%b want=%b", i, o, 12'h1E2);
      end
    end
    $display("add_stream: 5 cycles");
  endtask

  task automatic test_ldr();
    logic [11:0] o, e;
`ifdef LC3B_PIPE_PERF_EN
    logic [15:0] s0;
    s0 = stall_cycles;
`endif
    set_idle(); mem_dreq = 1'b1;
    for (int i = 0; i < 4; i++) begin
      dmem_resp = (i == 3);
      tick(o, e);
      total++;
      if (o !== e || o[11] !== 1'b1 || o[5] !== (i == 3)) begin
        bad++; $display("FAIL ldr cyc=%0d got=%b want=%b", i, o, e);
      end
    end
`ifdef LC3B_PIPE_PERF_EN
    total++;
    if (stall_cycles - s0 !== 16'd3) begin
      bad++; $display("FAIL ldr_stall_cycles got=%0d want=3", stall_cycles - s0);
    end
`endif
    set_idle(); tick(o, e);
    $display("ldr: resp at cycle 3");
  endtask

  task automatic test_ind(input logic st, input int r1, input int r2);
    logic [11:0] o, e;
    set_idle(); mem_dreq = 1'b1; mem_indirect = 1'b1; mem_dwrite = st;
    for (int i = 0; i <= r2; i++) begin
      dmem_resp = (i == r1) || (i == r2);
      tick(o, e);
      total++;
      if (o !== e || o[9] !== (i == r1) || o[5] !== (i == r2) ||
          o[11] !== (!st || i <= r1) || o[10] !== (st && i > r1)) begin
        bad++; $display("FAIL %s cyc=%0d got=%b want=%b", st ? "sti" : "ldi", i, o, e);
      end
    end
    set_idle(); tick(o, e);
    $display("%s: resp at cycles %0d and %0d", st ? "sti" : "ldi", r1, r2);
  endtask

  task automatic test_hold();
    logic [11:0] o, e;
    logic prev;
    int edges;
    prev = 1'b0; edges = 0;
    set_idle(); mem_dreq = 1'b1;
    for (int i = 0; i < 3; i++) begin
      imem_resp = (i == 2);
      dmem_resp = (i == 0);
      tick(o, e);
      if (o[11] && !prev) edges++;
      prev = o[11];
      total++;
      if (o !== e || o[5] !== (i == 2) || o[11] !== (i == 0)) begin
        bad++; $display("FAIL hold cyc=%0d got=%b want=%b", i, o, e);
      end
    end
    total++;
    if (edges !== 1) begin
      bad++; $display("FAIL hold_requests got=%0d want=1", edges);
    end
    set_idle(); tick(o, e);
    $display("hold: dmem done before imem");
  endtask

  task automatic test_ctrl();
    logic [11:0] o, e, want;
`ifdef LC3B_PIPE_PERF_EN
    logic [15:0] b0, r0;
    b0 = bubble_cnt; r0 = redirect_cnt;
`endif
    for (int i = 0; i < 5; i++) begin
      set_idle();
      case (i)
        0: begin id_load_use = 1'b1; mem_br_taken = 1'b1; want = 12'h03F; end
        1: begin id_load_use = 1'b1; want = 12'h068; end
        2: begin mem_br_taken = 1'b1; want = 12'h03F; end
        3: begin mem_br_taken = 1'b1; mem_dreq = 1'b1; want = 12'h800; end
        default: begin mem_dreq = 1'b1; dmem_resp = 1'b1; want = 12'h9E2; end
      endcase
      tick(o, e);
      total++;
      if (o !== want || o !== e) begin
        bad++; $display("FAIL ctrl case=%0d got=%b want=%b model=%b", i, o, want, e);
      end
    end
`ifdef LC3B_PIPE_PERF_EN
    total++;
    if (bubble_cnt - b0 !== 16'd1 || redirect_cnt - r0 !== 16'd2) begin
      bad++; $display("FAIL ctrl_counters got=%0d/%0d want=1/2", bubble_cnt - b0, redirect_cnt - r0);
    end
`endif
    set_idle(); tick(o, e);
    $display("ctrl: redirect and load-use priority");
  endtask

  task automatic test_reset_mid();
    logic [11:0] o, e;
    set_idle(); mem_dreq = 1'b1; mem_indirect = 1'b1; mem_dwrite = 1'b1;
    dmem_resp = 1'b1;
    tick(o, e);
    dmem_resp = 1'b0;
    tick(o, e);
    total++;
    if (o !== e || o[11:10] !== 2'b01) begin
      bad++; $display("FAIL rst_mid_acc2 got=%b want=%b", o, e);
    end
    rst_n = 1'b0; m_cnt = 0;
    #1;
    total++;
    if (outv !== 12'h01C) begin
      bad++; $display("FAIL rst_mid_low got=%b want=%b", outv, 12'h01C);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    tick(o, e);
    total++;
    if (o !== e || o[11:10] !== 2'b10) begin
      bad++; $display("FAIL rst_mid_acc1 got=%b want=%b", o, e);
    end
    set_idle(); tick(o, e);
    $display("reset_mid: abandoned indirect store");
  endtask

  task automatic test_random();
    logic [11:0] o, e;
    int need;
    set_idle();
    for (int i = 0; i < 400; i++) begin
      need = mem_indirect ? 2 : 1;
      imem_read = ($urandom % 8) != 0;
      imem_resp = imem_read && (($urandom % 3) != 0);
      dmem_resp = mem_dreq && (m_cnt < need) && (($urandom % 3) == 0);
      tick(o, e);
      total++;
      if (o !== e) begin
        bad++; $display("FAIL random cyc=%0d got=%b want=%b", i, o, e);
      end
      if (e[5]) begin
        mem_dreq     = $urandom % 2;
        mem_dwrite   = $urandom % 2;
        mem_indirect = $urandom % 2;
        id_load_use  = ($urandom % 4) == 0;
        mem_br_taken = ($urandom % 5) == 0;
      end
    end
`ifdef LC3B_PIPE_PERF_EN
    total++;
    if ({stall_cycles, bubble_cnt, redirect_cnt} !== {m_stall, m_bubble, m_redir}) begin
      bad++; $display("FAIL random_counters got=%h want=%h",
                      {stall_cycles, bubble_cnt, redirect_cnt}, {m_stall, m_bubble, m_redir});
    end
`endif
    set_idle(); tick(o, e);
    $display("random: 400 cycles");
  endtask

  initial begin
    total = 0; bad = 0; m_cnt = 0;
    test_reset();
    test_add_stream();
    test_ldr();
    test_ind(1'b0, 2, 5);
    test_ind(1'b1, 1, 3);
    test_hold();
    test_ctrl();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lc3b_pipe_ctrl.md
Name: lc3b_pipe_ctrl

Overview:
Central stall/flush sequencer for the 5-stage LC-3b pipeline. It drives the advance and flush inputs of the ifid, idex, exmem and memwb pipeline registers, and the PC load enable. It sequences MEM-stage data accesses, including the two-access LDI/STI indirect case, and arbitrates between memory stalls, load-use bubbles and taken-branch redirects.

Parameters:
CNT_W, 16, width of the optional performance counters.

Ports:
clk  in  1  pipeline clock
rst_n  in  1  asynchronous active-low reset
imem_read  in  1  IF stage fetch request
imem_resp  in  1  I-memory response, single-cycle pulse
mem_dreq  in  1  instruction in exmem needs a data access (ctrl word mem_read|mem_write)
mem_dwrite  in  1  that access is a store (final access only)
mem_indirect  in  1  exmem holds LDI/STI
dmem_resp  in  1  D-memory response pulse
id_load_use  in  1  idex holds a load whose dest matches an ID source register
mem_br_taken  in  1  exmem resolves a taken branch/JMP/TRAP redirect
dmem_read  out  1  D-memory read strobe
dmem_write  out  1  D-memory write strobe
ind_latch  out  1  pulse: datapath captures the indirect pointer into its MAR
advance_ifid, advance_idex, advance_exmem, advance_memwb  out  1 each  pipeline register advance
flush_ifid, flush_idex, flush_exmem  out  1 each  pipeline register synchronous clear
pc_load  out  1  PC register enable
pc_redirect  out  1  PC mux select for the branch target (1) vs pc+2 (0)

Behaviour:
- State register st ∈ {ACC1, ACC2, HOLD}; async reset to ACC1.
- While rst_n=0: all advance_*, dmem_*, pc_load, ind_latch and pc_redirect = 0; all flush_* = 1.
- ACC1: dmem_read = mem_dreq & (mem_indirect | ~mem_dwrite); dmem_write = mem_dreq & ~mem_indirect & mem_dwrite.
  - On dmem_resp with mem_indirect: ind_latch=1, go to ACC2.
  - On dmem_resp with ~mem_indirect: mem_done=1.
- ACC2: dmem_read = ~mem_dwrite; dmem_write = mem_dwrite. On dmem_resp: mem_done=1.
- HOLD: dmem strobes = 0; mem_done=1 (result already captured, no re-issue).
- istall = imem_read & ~imem_resp. dstall = mem_dreq & ~mem_done. stall = istall | dstall.
- mem_done & istall: go to HOLD. On ~stall from any state: go to ACC1.
- stall=1: all advance_* = 0, all flush = 0, pc_load = 0 (entire pipe frozen).
- ~stall & mem_br_taken: advance_memwb = 1; flush_ifid = flush_idex = flush_exmem = 1; pc_load = 1; pc_redirect = 1. Redirect overrides load-use.
- ~stall & id_load_use & ~mem_br_taken: advance_ifid = 0, pc_load = 0; flush_idex = 1 (bubble); advance_exmem = advance_memwb = 1.
- ~stall otherwise: all advance_* = 1, pc_load = 1.
- Outputs are combinational from st and inputs; the only added latency is the state register.
- Reset asserted mid-access returns to ACC1 immediately; the in-flight access is abandoned.

Optional Feature:
LC3B_PIPE_PERF_EN
- Defined: adds output ports stall_cycles, bubble_cnt and redirect_cnt, each CNT_W wide.
  - stall_cycles counts cycles with stall=1.
  - bubble_cnt counts load-use bubbles.
  - redirect_cnt counts taken redirects.
  - All counters saturate at all-ones and reset to 0.
- Undefined: ports and logic are absent; functional behaviour is identical.

Decomposition:
- lc3b_types gains lc3b_pctrl_state, an enum of ACC1, ACC2, HOLD.
- Sub-module pipe_perf_cnt: a saturating CNT_W counter with an increment enable, instantiated three times under the macro.

Test Plan:
- Plain ADD stream, imem_resp every cycle, no dreq → all advance=1 and pc_load=1 every cycle; no flushes.
- LDR with dmem_resp 3 cycles after dreq → all advance=0 for 3 cycles; dmem_read held; advance on the 4th cycle; st stays ACC1.
- LDI with dmem_resp at cycles 2 and 5 → ind_latch pulses at cycle 2; st=ACC2; dmem_read high cycles 0-5; advance only at cycle 5. STI: dmem_read in ACC1, then dmem_write in ACC2.
- dmem_resp while imem_resp is delayed by 2 cycles → st=HOLD; dmem strobes drop; advance only when imem_resp arrives; exactly one dmem request observed.
- id_load_use and mem_br_taken together, no stall → flush ifid/idex/exmem, pc_redirect=1, advance_memwb=1. id_load_use alone → flush_idex=1, advance_ifid=0, pc_load=0.
- rst_n pulled low during ACC2 → async return to ACC1; flush_*=1 while low. With LC3B_PIPE_PERF_EN, the LDR case gives stall_cycles=3.
